alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port arbiter and sequencer for the shared 8-bit ALU. It accepts operation requests (operands, 4-bit select, carry-in) from two requesters and grants them round-robin. It drives the ALU operand/select inputs and waits the ALU's fixed pipeline latency. It then captures `alu_y` and returns the result to the winning requester over a valid/ready response channel. Exactly one operation is in flight at a time.

## Interface
- `WIDTH`, 8: operand/result width.
- `SEL_W`, 4: ALU select width.
- `LAT`, 2: number of clock edges from the issue edge to the capture edge. Must be ≥1; 2 matches the ALU's posedge-unit/negedge-mux pipeline.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `r0_valid` in 1: port 0 request valid.
- `r0_ready` out 1: port 0 request accepted this cycle.
- `r0_a`, `r0_b` in WIDTH: port 0 operands.
- `r0_sel` in SEL_W: port 0 ALU select.
- `r0_c_in` in 1: port 0 carry-in.
- `r0_rsp_valid` out 1: port 0 result valid.
- `r0_rsp_ready` in 1: port 0 result consumed.
- `r0_y` out WIDTH: port 0 result.
- `r1_*`: identical set for port 1.
- `alu_a`, `alu_b` out WIDTH: registered ALU operands.
- `alu_sel` out SEL_W: registered ALU select.
- `alu_c_in` out 1: registered ALU carry-in.
- `alu_y` in WIDTH: ALU result.
- `busy` out 1: high when the state is not IDLE.

## Operation
- **FSM states.** IDLE, EXEC, RESP. Additional state:
  - `owner` (1 bit): port that holds the current grant.
  - `last` (1 bit): port most recently completed.
  - `cnt` (clog2(LAT+1) bits): latency counter.
  - `y_q` (WIDTH): captured result.
- **Grant (combinational, IDLE only).**
  - If only one port is valid, grant that port.
  - If both are valid, grant `~last`.
  - If neither is valid, no grant.
- **Ready.** `rN_ready = (state==IDLE) && rN_valid && grant==N`. Never more than one ready is high. Ready is 0 outside IDLE.
- **IDLE → EXEC** on handshake (`valid && ready`):
  - Load `alu_a/b/sel/c_in` from the granted port.
  - Set `owner` to the granted port.
  - Set `cnt = LAT`.
- **EXEC.**
  - `cnt` decrements each edge.
  - On the edge where `cnt==1`: capture `y_q <= alu_y` and move to RESP.
  - `alu_*` are held constant throughout EXEC.
- **RESP.**
  - `r<owner>_rsp_valid = 1` and `r<owner>_y = y_q`. The other port's `rsp_valid` is 0.
  - Stays in RESP until `rsp_ready` from the owner port. On that edge: set `last <= owner` and move to IDLE.
- **Result outputs.** `rN_y` shows `y_q` at all times; it is only meaningful while `rN_rsp_valid` is high.
- **After completion.** `alu_*` retain the last issued values. They are not cleared.
- **Request stability.** Requests are sampled only at the handshake edge. Requester fields may change freely at other times.
- **Withdrawn request.** A request withdrawn before the handshake is simply not granted; no error is raised.
- **Width rules.**
  - No arithmetic is performed on data. The result is `alu_y` passed through unmodified.
  - Carry-out is not provided.

## Timing
- **Reset values** (asynchronous assertion, synchronous release):
  - State IDLE, `last=1` (port 0 wins the first contention), `owner=0`, `cnt=0`, `y_q=0`.
  - `alu_a=alu_b=0`, `alu_sel=0`, `alu_c_in=0`, `busy=0`.
  - All `rsp_valid=0`, all `ready=0` while `rst_n` is low.
- **Latency.** Handshake at edge T0 → `alu_*` valid after T0 → capture at edge T0+LAT → `rsp_valid` high after T0+LAT.
- **Throughput.** Minimum occupancy per operation is LAT+2 cycles (1 IDLE, LAT EXEC, ≥1 RESP). With LAT=2: 4 cycles.
- **Back-pressure.** If `rsp_ready` stays low, the block holds RESP indefinitely. Both `ready` outputs stay 0 and `y_q` is stable.
- **Simultaneous requests.** Round-robin alternates strictly under continuous contention: 0, 1, 0, 1…
- **Contention while busy.** A request from the non-owner port during EXEC/RESP waits. It is granted in the next IDLE cycle.
- **Reset mid-operation.** The operation is discarded and no response is produced. After release, the arbiter behaves as from power-up.

## Test plan
Bench ALU model: `y = (a + b + c_in) mod 256`, registered with 2-cycle latency; LAT=2.
- **Single request.** Port 0 requests a=0x12, b=0x34, c_in=1 in IDLE.
  - `r0_ready` pulses for 1 cycle; `busy` rises.
  - `r0_rsp_valid` rises 2 edges after the handshake with `r0_y=0x47`.
  - `r0_rsp_ready=1` → IDLE next edge.
- **Simultaneous requests after reset.** Both ports request (p0: 0x01+0x01, p1: 0x10+0x10).
  - Port 0 is served first (y=0x02), then port 1 (y=0x20).
  - `r1_ready` stays 0 until the next IDLE.
- **Continuous contention.** Both ports hold valid for 6 operations.
  - Grant order is 0,1,0,1,0,1.
  - Each operation occupies exactly 4 cycles when `rsp_ready` is tied high.
- **Back-pressure.** Hold `r1_rsp_ready=0` for 10 cycles in RESP (y=0xFF from 0xFE+0x00+1).
  - `r1_y` stays 0xFF and `busy` stays 1.
  - Port 0 requests are not accepted until release.
- **Wrap-around.** Request a=0xFF, b=0x01, c_in=1 → `y=0x01`. Operands are passed to the ALU unmodified.
- **Reset mid-EXEC.** Assert `rst_n=0` one cycle after a handshake.
  - All outputs return to reset values immediately.
  - No `rsp_valid` appears after release.
  - The next contended grant goes to port 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin two-port front end for the shared ALU: grants one request at a time,
// drives registered operands, waits LAT edges, then returns alu_y to the owner port.
module alu_arbiter #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 4,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic [SEL_W-1:0] r0_sel,
    input  logic             r0_c_in,
    output logic             r0_rsp_valid,
    input  logic             r0_rsp_ready,
    output logic [WIDTH-1:0] r0_y,

    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic [SEL_W-1:0] r1_sel,
    input  logic             r1_c_in,
    output logic             r1_rsp_valid,
    input  logic             r1_rsp_ready,
    output logic [WIDTH-1:0] r1_y,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    output logic             alu_c_in,
    input  logic [WIDTH-1:0] alu_y,

    output logic             busy
);

    localparam int CNT_W = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic               owner_reg;
    logic               last_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   y_q_reg;

    logic               grant_vld;
    logic               grant;
    logic               handshake;
    logic               owner_rsp_ready;

    // Arbitration is only live in IDLE; ties go to the port that did not finish last.
    always_comb begin
        grant_vld = 1'b0;
        grant     = 1'b0;
        if (state_reg == IDLE) begin
            case ({r1_valid, r0_valid})
                2'b01: begin
                    grant_vld = 1'b1;
                    grant     = 1'b0;
                end
                2'b10: begin
                    grant_vld = 1'b1;
                    grant     = 1'b1;
                end
                2'b11: begin
                    grant_vld = 1'b1;
                    grant     = ~last_reg;
                end
                default: begin
                    grant_vld = 1'b0;
                    grant     = 1'b0;
                end
            endcase
        end
    end

    // rst_n gating keeps both readies low while reset is held, even with valid requests.
    assign r0_ready        = rst_n && grant_vld && !grant;
    assign r1_ready        = rst_n && grant_vld && grant;
    assign handshake       = r0_ready || r1_ready;
    assign owner_rsp_ready = owner_reg ? r1_rsp_ready : r0_rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (handshake) state_next = EXEC;
            EXEC: if (cnt_reg == CNT_W'(1)) state_next = RESP;
            RESP: if (owner_rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_reg != IDLE);
        r0_rsp_valid = (state_reg == RESP) && !owner_reg;
        r1_rsp_valid = (state_reg == RESP) && owner_reg;
        r0_y         = y_q_reg;
        r1_y         = y_q_reg;
    end

    // ALU operands persist after completion; only a new handshake or reset changes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_reg <= 1'b0;
            last_reg  <= 1'b1;
            cnt_reg   <= '0;
            y_q_reg   <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            alu_c_in  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (handshake) begin
                        owner_reg <= grant;
                        cnt_reg   <= CNT_W'(LAT);
                        alu_a     <= grant ? r1_a    : r0_a;
                        alu_b     <= grant ? r1_b    : r0_b;
                        alu_sel   <= grant ? r1_sel  : r0_sel;
                        alu_c_in  <= grant ? r1_c_in : r0_c_in;
                    end
                end
                EXEC: begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        y_q_reg <= alu_y;
                    end
                end
                RESP: begin
                    if (owner_rsp_ready) begin
                        last_reg <= owner_reg;
                    end
                end
                default: begin
                    cnt_reg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a two-stage adder ALU model and a result scoreboard.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       r0_valid, r0_ready, r0_c_in, r0_rsp_valid, r0_rsp_ready;
    logic [7:0] r0_a, r0_b, r0_y;
    logic [3:0] r0_sel;
    logic       r1_valid, r1_ready, r1_c_in, r1_rsp_valid, r1_rsp_ready;
    logic [7:0] r1_a, r1_b, r1_y;
    logic [3:0] r1_sel;
    logic [7:0] alu_a, alu_b;
    logic [3:0] alu_sel;
    logic       alu_c_in;
    logic [7:0] alu_y = 8'h00;
    logic [7:0] alu_s1 = 8'h00;
    logic       busy;

    typedef struct packed {
        logic       port;
        logic [7:0] y;
    } exp_t;

    exp_t sb[$];
    logic grant_log[$];
    int   hs_cyc[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   left0 = 0;
    int   left1 = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(8), .SEL_W(4), .LAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
        .r0_sel(r0_sel), .r0_c_in(r0_c_in), .r0_rsp_valid(r0_rsp_valid),
        .r0_rsp_ready(r0_rsp_ready), .r0_y(r0_y),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
        .r1_sel(r1_sel), .r1_c_in(r1_c_in), .r1_rsp_valid(r1_rsp_valid),
        .r1_rsp_ready(r1_rsp_ready), .r1_y(r1_y),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_c_in(alu_c_in),
        .alu_y(alu_y), .busy(busy)
    );

    // ALU: adder stage on the rising edge, output mux on the falling edge.
    always_ff @(posedge clk) alu_s1 <= alu_a + alu_b + {7'd0, alu_c_in};
    always_ff @(negedge clk) alu_y <= alu_s1;

    function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + {8'd0, c};
        return s[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes at the falling edge, advance, then update scoreboard.
    task automatic cycle();
        logic hs0, hs1, rs0, rs1;
        logic [7:0] a0, b0, a1, b1, yo;
        logic c0, c1;
        exp_t e;
        @(negedge clk);
        hs0 = r0_ready; hs1 = r1_ready;
        a0 = r0_a; b0 = r0_b; c0 = r0_c_in;
        a1 = r1_a; b1 = r1_b; c1 = r1_c_in;
        rs0 = r0_rsp_valid && r0_rsp_ready;
        rs1 = r1_rsp_valid && r1_rsp_ready;
        yo  = rs1 ? r1_y : r0_y;
        chk("ready_onehot", {31'd0, r0_ready & r1_ready}, 0);
        chk("rsp_onehot", {31'd0, r0_rsp_valid & r1_rsp_valid}, 0);
        @(posedge clk);
        #1;
        cyc++;
        if (hs0) begin
            sb.push_back('{port: 1'b0, y: model(a0, b0, c0)});
            grant_log.push_back(1'b0);
            hs_cyc.push_back(cyc);
            if (left0 > 0) left0--;
            if (left0 == 0) r0_valid = 1'b0;
            else begin
                r0_a = 8'($urandom_range(0, 255));
                r0_b = 8'($urandom_range(0, 255));
                r0_c_in = 1'($urandom_range(0, 1));
            end
        end
        if (hs1) begin
            sb.push_back('{port: 1'b1, y: model(a1, b1, c1)});
            grant_log.push_back(1'b1);
            hs_cyc.push_back(cyc);
            if (left1 > 0) left1--;
            if (left1 == 0) r1_valid = 1'b0;
            else begin
                r1_a = 8'($urandom_range(0, 255));
                r1_b = 8'($urandom_range(0, 255));
                r1_c_in = 1'($urandom_range(0, 1));
            end
        end
        if (rs0 || rs1) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", {31'd0, rs1}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("rsp_port", {31'd0, rs1}, {31'd0, e.port});
                chk("rsp_y", {24'd0, yo}, {24'd0, e.y});
            end
        end
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (!(sb.size() == 0 && !busy && !r0_valid && !r1_valid) && n < budget) begin
            cycle();
            n++;
        end
        chk({tag, "_done"}, {31'd0, (n < budget)}, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        r0_valid = 1'b0; r1_valid = 1'b0;
        r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
        left0 = 0; left1 = 0;
        sb.delete(); grant_log.delete(); hs_cyc.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        r0_valid = 1'b1; r1_valid = 1'b1;
        r0_a = 8'h00; r0_b = 8'h00; r0_sel = 4'h0; r0_c_in = 1'b0; r0_rsp_ready = 1'b0;
        r1_a = 8'h00; r1_b = 8'h00; r1_sel = 4'h0; r1_c_in = 1'b0; r1_rsp_ready = 1'b0;
        #2;
        chk("rst_r0_ready", {31'd0, r0_ready}, 0);
        chk("rst_r1_ready", {31'd0, r1_ready}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_alu_a", {24'd0, alu_a}, 0);
        chk("rst_rsp", {30'd0, r0_rsp_valid, r1_rsp_valid}, 0);
        chk("rst_y", {24'd0, r0_y}, 0);
        do_reset();

        // Single request on port 0
        r0_a = 8'h12; r0_b = 8'h34; r0_c_in = 1'b1; r0_sel = 4'h3;
        r0_valid = 1'b1; left0 = 1;
        #1;
        chk("t1_ready_hi", {31'd0, r0_ready}, 1);
        chk("t1_r1_ready_lo", {31'd0, r1_ready}, 0);
        chk("t1_busy_lo", {31'd0, busy}, 0);
        cycle();
        chk("t1_ready_pulse", {31'd0, r0_ready}, 0);
        chk("t1_busy_hi", {31'd0, busy}, 1);
        chk("t1_alu_ops", {12'd0, alu_sel, alu_c_in, 3'd0, alu_a, alu_b}, {12'd0, 4'h3, 1'b1, 3'd0, 8'h12, 8'h34});
        chk("t1_rsp_lat1", {31'd0, r0_rsp_valid}, 0);
        cycle();
        chk("t1_rsp_lat2", {31'd0, r0_rsp_valid}, 0);
        cycle();
        chk("t1_rsp_valid", {31'd0, r0_rsp_valid}, 1);
        chk("t1_r1_rsp_lo", {31'd0, r1_rsp_valid}, 0);
        chk("t1_y", {24'd0, r0_y}, 32'h47);
        r0_rsp_ready = 1'b1;
        cycle();
        chk("t1_idle", {31'd0, busy}, 0);
        chk("t1_sb_empty", sb.size(), 0);

        // Simultaneous requests right after reset: port 0 first
        do_reset();
        r0_a = 8'h01; r0_b = 8'h01; r0_c_in = 1'b0;
        r1_a = 8'h10; r1_b = 8'h10; r1_c_in = 1'b0;
        r0_valid = 1'b1; r1_valid = 1'b1; left0 = 1; left1 = 1;
        r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
        #1;
        chk("t2_r0_ready", {31'd0, r0_ready}, 1);
        chk("t2_r1_wait", {31'd0, r1_ready}, 0);
        cycle();
        repeat (2) begin
            cycle();
            chk("t2_r1_wait_busy", {31'd0, r1_ready}, 0);
        end
        cycle();
        chk("t2_r1_next_idle", {31'd0, r1_ready}, 1);
        run_until_idle("t2", 20);
        chk("t2_order", {30'd0, grant_log.size() == 2 ? {grant_log[0], grant_log[1]} : 2'b11}, 32'b01);

        // Continuous contention, responses always accepted
        grant_log.delete(); hs_cyc.delete();
        r0_valid = 1'b1; r1_valid = 1'b1; left0 = 3; left1 = 3;
        run_until_idle("t3", 60);
        chk("t3_count", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
            chk($sformatf("t3_grant%0d", i), {31'd0, grant_log[i]}, i % 2);
        end
        for (int i = 1; i < hs_cyc.size(); i++) begin
            chk($sformatf("t3_occ%0d", i), hs_cyc[i] - hs_cyc[i-1], 4);
        end

        // Back-pressure on port 1 with port 0 waiting
        grant_log.delete();
        r1_rsp_ready = 1'b0;
        r1_a = 8'hFE; r1_b = 8'h00; r1_c_in = 1'b1; r1_valid = 1'b1; left1 = 1;
        cycle();
        r0_a = 8'h05; r0_b = 8'h06; r0_c_in = 1'b0; r0_valid = 1'b1; left0 = 1;
        n = 0;
        while (!r1_rsp_valid && n < 10) begin
            cycle();
            n++;
        end
        chk("t4_rsp_seen", {31'd0, r1_rsp_valid}, 1);
        repeat (10) begin
            cycle();
            chk("t4_hold_valid", {31'd0, r1_rsp_valid}, 1);
            chk("t4_hold_y", {24'd0, r1_y}, 32'hFF);
            chk("t4_busy", {31'd0, busy}, 1);
            chk("t4_r0_blocked", {31'd0, r0_ready}, 0);
        end
        r1_rsp_ready = 1'b1;
        run_until_idle("t4", 20);
        chk("t4_order", {30'd0, grant_log.size() == 2 ? {grant_log[0], grant_log[1]} : 2'b11}, 32'b10);

        // Wrap-around operands pass through unmodified
        r0_a = 8'hFF; r0_b = 8'h01; r0_c_in = 1'b1; r0_valid = 1'b1; left0 = 1;
        cycle();
        chk("t5_alu_ops", {15'd0, alu_c_in, alu_a, alu_b}, {15'd0, 1'b1, 8'hFF, 8'h01});
        run_until_idle("t5", 20);

        // Reset one cycle into EXEC
        r0_a = 8'h33; r0_b = 8'h44; r0_c_in = 1'b0; r0_valid = 1'b1; left0 = 1;
        cycle();
        cycle();
        chk("t6_in_exec", {31'd0, busy}, 1);
        rst_n = 1'b0;
        r0_valid = 1'b1; r1_valid = 1'b1;
        #1;
        chk("t6_busy", {31'd0, busy}, 0);
        chk("t6_alu", {24'd0, alu_a | alu_b}, 0);
        chk("t6_ready", {30'd0, r0_ready, r1_ready}, 0);
        chk("t6_rsp", {30'd0, r0_rsp_valid, r1_rsp_valid}, 0);
        sb.delete(); grant_log.delete();
        repeat (2) @(posedge clk);
        r0_valid = 1'b0; r1_valid = 1'b0; left0 = 0; left1 = 0;
        #1 rst_n = 1'b1;
        repeat (4) begin
            cycle();
            chk("t6_no_rsp", {30'd0, r0_rsp_valid, r1_rsp_valid}, 0);
        end
        r0_valid = 1'b1; r1_valid = 1'b1; left0 = 1; left1 = 1;
        run_until_idle("t6", 20);
        chk("t6_first_grant", {31'd0, grant_log.size() > 0 ? grant_log[0] : 1'b1}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
